// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator for two WIDTH-bit unsigned operands.
// Optional early completion on the first differing bit: define SERIAL_CMP_EARLY_DONE_EN.
module serial_mag_comparator #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic a_grt_b,
  output logic a_less_b,
  output logic a_eql_b
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_CMP_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {EQ = 2'd0, GT = 2'd1, LT = 2'd2} dec_t;

  state_t          state, state_n;
  dec_t            dec, dec_n, bit_dec;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      flags, flags_n;
  logic            finish;
  logic            accept;

  always_comb begin
    bit_dec = EQ;
    if (a_bit && !b_bit) bit_dec = GT;
    else if (!a_bit && b_bit) bit_dec = LT;
  end

  // start always wins: it restarts from a fresh MSB, aborting any comparison in flight
  always_comb begin
    state_n = state;
    dec_n   = dec;
    cnt_n   = cnt;
    flags_n = flags;
    finish  = 1'b0;
    accept  = 1'b0;
    if (start) begin
      accept = 1'b1;
      dec_n  = bit_dec;
      cnt_n  = CW'(1);
      finish = (WIDTH == 1) || (EARLY && (bit_dec != EQ));
    end else if (state == SHIFT && bit_valid) begin
      accept = 1'b1;
      if (dec == EQ) dec_n = bit_dec;
      cnt_n  = cnt + 1'b1;
      finish = (cnt == LAST) || (EARLY && (dec_n != EQ));
    end
    if (accept) state_n = finish ? IDLE : SHIFT;
    if (finish) begin
      cnt_n = '0;
      case (dec_n)
        GT:      flags_n = 3'b100;
        LT:      flags_n = 3'b010;
        default: flags_n = 3'b001;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dec   <= EQ;
      cnt   <= '0;
      flags <= 3'b000;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      dec   <= dec_n;
      cnt   <= cnt_n;
      flags <= flags_n;
      done  <= finish;
    end
  end

  assign busy     = (state == SHIFT);
  assign a_grt_b  = flags[2];
  assign a_less_b = flags[1];
  assign a_eql_b  = flags[0];

endmodule
